sc_stream_sequencer: RTL and testbench
======================================

# sc_stream_sequencer

Controller that sequences one evaluation of the 8-bit stochastic-computing circuit: seeds and closes its LFSR state loop, supplies the comparator constant, releases the circuit's hold, discards warm-up bits while the delay elements settle, and counts the 1s of the output stream over a programmable length. It sits between the host/register interface and one `circuit` instance. It converts a start/done request into a binary result (ones count).

## Interface

Parameters:
- `WARMUP`, 2, number of discarded cycles after LOAD so the delay flip-flops fill.
- `DEFAULT_SEED`, 8'h01, seed substituted when `seed_i` is 0, because an all-zero state locks up the LFSR.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high despite the name (1 = reset), matching the circuit's hold polarity.
- `start_i`  in  1  request; sampled only in IDLE or DONE.
- `seed_i`  in  8  LFSR seed, latched on accepted start.
- `b_i`  in  8  comparator constant, latched on accepted start.
- `len_i`  in  9  stream length 0..256, latched on accepted start.
- `busy_o`  out  1  high in LOAD, WARM and RUN.
- `done_o`  out  1  one-cycle pulse in DONE.
- `result_o`  out  9  ones count. Held from DONE until the next accepted start.
- `sc_s_o`  out  8  to circuit `input_s`.
- `sc_s_i`  in  8  from circuit `output_s`, the registered next state.
- `sc_b_o`  out  8  to circuit `input_b`, equal to the latched b.
- `sc_hold_o`  out  1  to circuit `rst_n`; 1 zeroes the circuit registers, 0 lets them run.
- `sc_bit_i`  in  1  from circuit `output_circuit`.

## Operation

- FSM states: IDLE, LOAD, WARM, RUN, DONE.
- IDLE → LOAD on `start_i`.
  - Latches seed_q, which is `DEFAULT_SEED` if `seed_i`==0, otherwise `seed_i`.
  - Latches b_q and len_q.
  - Clears the ones counter and the cycle counter.
- IDLE → DONE directly if `start_i` is high and `len_i`==0. The result is 0 and the circuit is never released.
- LOAD, 1 cycle:
  - `sc_hold_o`=0, `sc_s_o`=seed_q.
  - The bit is discarded.
  - Next state is WARM, or RUN if `WARMUP`==0.
- WARM, `WARMUP` cycles:
  - `sc_hold_o`=0, `sc_s_o`=`sc_s_i`.
  - Bits are discarded.
- RUN, len_q cycles:
  - `sc_hold_o`=0, `sc_s_o`=`sc_s_i`.
  - The ones counter increments when `sc_bit_i`=1.
  - After the last cycle, go to DONE.
- DONE, 1 cycle:
  - `done_o`=1, `result_o`=ones count, `sc_hold_o`=1.
  - A start in DONE is accepted exactly as in IDLE; otherwise go to IDLE.
- In IDLE and DONE: `sc_hold_o`=1 and `sc_s_o`=seed_q.
- `sc_b_o`=b_q in all states.
- `start_i` in LOAD, WARM or RUN is ignored. There is no queueing.
- Counters are 9-bit. The ones count is at most len_q ≤ 256, so it never wraps. The cycle counter compares against len_q−1 and WARMUP−1.

## Timing

- Reset, asynchronous, all outputs in the same cycle:
  - state=IDLE
  - `busy_o`=0, `done_o`=0, `result_o`=0
  - `sc_hold_o`=1
  - seed_q=`DEFAULT_SEED`, so `sc_s_o`=8'h01
  - b_q=0, so `sc_b_o`=0
  - len_q=0, counters=0
- Reset asserted mid-run aborts the run. No `done_o` is produced and `result_o`=0 after release.
- Cycle numbering: start is sampled at edge E; cycle E+k is the period after edge E+k−1.
  - LOAD = E+1.
  - WARM = E+2 .. E+1+WARMUP.
  - RUN = E+2+WARMUP .. E+1+WARMUP+len.
  - DONE = E+2+WARMUP+len.
- Total latency from start to done is 2+WARMUP+len cycles (260 for defaults with len=256). For len=0 it is 1 cycle.
- `busy_o` is registered-state decoded: it is high in cycles E+1 through E+1+WARMUP+len.
- `sc_s_o` changes the cycle after each active edge. It follows the circuit's registered `output_s`, so state advances once per cycle while `sc_hold_o`=0.
- All outputs are glitch-free state decodes. There is no combinational path from `start_i`.

## Test plan

- Circuit stub with `sc_bit_i`=1, seed 8'h01, b=8'h80, len=200, WARMUP=2 → `done_o` pulses at E+204 and `result_o`=200. `busy_o` is high for exactly 203 cycles.
- Real circuit, seed 8'h01 → `sc_s_o`=8'h01 in LOAD and 8'h80 in the first WARM cycle. With b=0, `result_o`=0 for len=256 because the comparator never fires.
- seed_i=0 → `sc_s_o`=8'h01 in LOAD. Over 255 RUN cycles `sc_s_o` is never 0 and no state repeats.
- len=0 → `done_o` at E+1, `result_o`=0, `sc_hold_o` never drops. Then back-to-back: a start in DONE with len=5 and stub bit=1 gives `result_o`=5.
- `start_i` pulsed in RUN with different seed/b/len → no effect on the latched values or the result. Done arrives at the original cycle.
- `rst_n` asserted at RUN cycle 50 → immediately `busy_o`=0, `sc_hold_o`=1, `result_o`=0. No `done_o` pulse. A new start after release completes normally.

Source files
------------

// File: rtl/sc_stream_sequencer.sv
`timescale 1ns/1ps
// Sequencer for one evaluation of the 8-bit stochastic-computing circuit:
// seeds the LFSR loop, releases the circuit hold, skips warm-up bits and counts ones.
module sc_stream_sequencer #(
  parameter int          WARMUP       = 2,
  parameter logic [7:0]  DEFAULT_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] seed_i,
  input  logic [7:0] b_i,
  input  logic [8:0] len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [8:0] result_o,
  output logic [7:0] sc_s_o,
  input  logic [7:0] sc_s_i,
  output logic [7:0] sc_b_o,
  output logic       sc_hold_o,
  input  logic       sc_bit_i
);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, RUN, DONE} state_t;

  localparam logic [8:0] WARM_LAST = 9'(WARMUP - 1);

  state_t     state_q, state_d;
  logic [7:0] seed_q, b_q;
  logic [8:0] len_q, ones_q, cnt_q;
  logic       accept;

  // An all-zero LFSR state never leaves zero, so substitute a legal seed.
  function automatic logic [7:0] safe_seed(input logic [7:0] s);
    return (s == 8'h00) ? DEFAULT_SEED : s;
  endfunction

  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (len_i == 9'd0) ? DONE : LOAD;
      end
      DONE: begin
        if (start_i) state_d = (len_i == 9'd0) ? DONE : LOAD;
        else         state_d = IDLE;
      end
      LOAD:    state_d = (WARMUP == 0) ? RUN : WARM;
      WARM:    if (cnt_q == WARM_LAST) state_d = RUN;
      RUN:     if (cnt_q == len_q - 9'd1) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      seed_q  <= DEFAULT_SEED;
      b_q     <= 8'h00;
      len_q   <= 9'd0;
      ones_q  <= 9'd0;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        seed_q <= safe_seed(seed_i);
        b_q    <= b_i;
        len_q  <= len_i;
        ones_q <= 9'd0;
        cnt_q  <= 9'd0;
      end else begin
        case (state_q)
          // Counter restarts at zero so RUN can reuse it for the stream length.
          WARM: cnt_q <= (cnt_q == WARM_LAST) ? 9'd0 : cnt_q + 9'd1;
          RUN: begin
            cnt_q <= cnt_q + 9'd1;
            if (sc_bit_i) ones_q <= ones_q + 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o    = (state_q == LOAD) || (state_q == WARM) || (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign sc_hold_o = !busy_o;
  // Once seeded, the loop is closed through the circuit's registered next state.
  assign sc_s_o    = ((state_q == WARM) || (state_q == RUN)) ? sc_s_i : seed_q;
  assign sc_b_o    = b_q;
  assign result_o  = ones_q;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
`timescale 1ns/1ps
// Randomized self-checking bench for sc_stream_sequencer with a behavioural
// circuit stub (LFSR + comparator) and a cycle-schedule reference model.
module tb_sc_stream_sequencer;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] seed_i = 8'h00;
  logic [7:0] b_i = 8'h00;
  logic [8:0] len_i = 9'd0;
  logic       busy_o, done_o, sc_hold_o, sc_bit_i;
  logic [8:0] result_o;
  logic [7:0] sc_s_o, sc_s_i, sc_b_o;

  int total = 0;
  int bad = 0;

  sc_stream_sequencer #(.WARMUP(W), .DEFAULT_SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i), .b_i(b_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .sc_s_o(sc_s_o), .sc_s_i(sc_s_i), .sc_b_o(sc_b_o), .sc_hold_o(sc_hold_o),
    .sc_bit_i(sc_bit_i)
  );

  always #5 clk = ~clk;

  // x^8+x^4+x^3+x^2+1, shifting right with feedback into the MSB (01 -> 80).
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  function automatic int done_at(input logic [8:0] l);
    return (l == 9'd0) ? 1 : 2 + W + int'(l);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Circuit stub: mode 0 = constant 1, 1 = comparator s<b, 2 = random bits.
  int         mode = 0;
  logic [7:0] circ_s = 8'h00;
  logic       circ_bit = 1'b0;
  always @(posedge clk) begin
    if (sc_hold_o) begin
      circ_s   <= 8'h00;
      circ_bit <= 1'b0;
    end else begin
      circ_s <= lfsr_next(sc_s_o);
      case (mode)
        0:       circ_bit <= 1'b1;
        1:       circ_bit <= (sc_s_o < sc_b_o);
        default: circ_bit <= 1'($urandom);
      endcase
    end
  end
  assign sc_s_i   = circ_s;
  assign sc_bit_i = circ_bit;

  // Reference model: cycle index since accepted start drives every expectation.
  bit         m_act = 1'b0;
  int         m_k = 0;
  logic [7:0] m_seed = 8'h01, m_b = 8'h00, m_st = 8'h00;
  logic [8:0] m_len = 9'd0, m_ones = 9'd0, m_res = 9'd0;

  initial forever begin
    bit busy_e, done_e;
    @(negedge clk);
    if (rst_n) begin
      m_act = 1'b0; m_k = 0; m_seed = 8'h01; m_b = 8'h00;
      m_len = 9'd0; m_ones = 9'd0; m_res = 9'd0;
    end
    busy_e = m_act && (m_len != 9'd0) && (m_k <= 1 + W + int'(m_len));
    done_e = m_act && (m_k == done_at(m_len));
    chk("busy", 32'(busy_o), 32'(busy_e));
    chk("done", 32'(done_o), 32'(done_e));
    chk("hold", 32'(sc_hold_o), 32'(!busy_e));
    chk("sc_b", 32'(sc_b_o), 32'(m_b));
    chk("sc_s", 32'(sc_s_o), 32'(busy_e ? m_st : m_seed));
    if (done_e)      chk("result_done", 32'(result_o), 32'(m_ones));
    else if (!m_act) chk("result_idle", 32'(result_o), 32'(m_res));
    if (busy_e && m_k >= 2 + W) m_ones = m_ones + 9'(sc_bit_i);
    if (!rst_n) begin
      if ((!m_act || done_e) && start_i) begin
        m_act  = 1'b1; m_k = 1;
        m_seed = (seed_i == 8'h00) ? 8'h01 : seed_i;
        m_b    = b_i; m_len = len_i; m_ones = 9'd0; m_st = m_seed;
      end else if (done_e) begin
        m_act = 1'b0; m_res = m_ones;
      end else if (m_act) begin
        m_k++; m_st = lfsr_next(m_st);
      end
    end
  end

  task automatic run_txn(input logic [7:0] seed, input logic [7:0] b, input logic [8:0] len,
                         input int md, input int pulse_k,
                         output int done_k, output int busy_n, output logic [8:0] res,
                         output logic [7:0] s1, output logic [7:0] s2, output int dup);
    bit [255:0] seen;
    seen = '0; dup = 0; busy_n = 0; done_k = 0; res = 9'd0; s1 = 8'h00; s2 = 8'h00;
    mode = md;
    @(posedge clk); #2;
    start_i = 1'b1; seed_i = seed; b_i = b; len_i = len;
    @(posedge clk); #2;
    start_i = 1'b0; seed_i = 8'($urandom); b_i = 8'($urandom); len_i = 9'($urandom);
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (k == 1) s1 = sc_s_o;
      if (k == 2) s2 = sc_s_o;
      if (busy_o) busy_n++;
      if (busy_o && k >= 2 + W) begin
        if (sc_s_o == 8'h00 || seen[sc_s_o]) dup++;
        seen[sc_s_o] = 1'b1;
      end
      if (done_o) begin
        done_k = k; res = result_o;
        break;
      end
      @(posedge clk); #2;
      start_i = (k + 1 == pulse_k);
      seed_i = 8'($urandom); b_i = 8'($urandom); len_i = 9'($urandom);
    end
    start_i = 1'b0;
  endtask

  initial begin
    int dk, bn, dp, cnt;
    logic [8:0] rs, l;
    logic [7:0] s1, s2, sd, bb;
    int md, pk, r;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hold", 32'(sc_hold_o), 32'd1);
    chk("rst_sc_s", 32'(sc_s_o), 32'h01);
    chk("rst_sc_b", 32'(sc_b_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);

    run_txn(8'h01, 8'h80, 9'd200, 0, 0, dk, bn, rs, s1, s2, dp);
    chk("ones_latency", 32'(dk), 32'd204);
    chk("ones_busy_len", 32'(bn), 32'd203);
    chk("ones_result", 32'(rs), 32'd200);

    run_txn(8'h01, 8'h00, 9'd256, 1, 0, dk, bn, rs, s1, s2, dp);
    chk("cmp_load_s", 32'(s1), 32'h01);
    chk("cmp_warm_s", 32'(s2), 32'h80);
    chk("cmp_b0_result", 32'(rs), 32'd0);
    chk("cmp_latency", 32'(dk), 32'd260);

    run_txn(8'h00, 8'h40, 9'd255, 1, 0, dk, bn, rs, s1, s2, dp);
    chk("zero_seed_load", 32'(s1), 32'h01);
    chk("zero_seed_unique", 32'(dp), 32'd0);

    // len=0 then back-to-back start from DONE.
    mode = 0;
    @(posedge clk); #2;
    start_i = 1'b1; seed_i = 8'h11; b_i = 8'h22; len_i = 9'd0;
    @(posedge clk); #2;
    len_i = 9'd5;
    @(negedge clk);
    chk("len0_done", 32'(done_o), 32'd1);
    chk("len0_result", 32'(result_o), 32'd0);
    chk("len0_hold", 32'(sc_hold_o), 32'd1);
    @(posedge clk); #2;
    start_i = 1'b0;
    dk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_o) begin dk = k; rs = result_o; break; end
    end
    chk("b2b_latency", 32'(dk), 32'd9);
    chk("b2b_result", 32'(rs), 32'd5);

    run_txn(8'h33, 8'h10, 9'd50, 0, 20, dk, bn, rs, s1, s2, dp);
    chk("ignore_start_latency", 32'(dk), 32'd54);
    chk("ignore_start_result", 32'(rs), 32'd50);

    // Reset during RUN cycle 50.
    mode = 0;
    @(posedge clk); #2;
    start_i = 1'b1; seed_i = 8'h5A; b_i = 8'h80; len_i = 9'd200;
    @(posedge clk); #2;
    start_i = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      @(posedge clk); #2;
    end
    rst_n = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_hold", 32'(sc_hold_o), 32'd1);
    chk("abort_result", 32'(result_o), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_o) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    run_txn(8'h07, 8'h80, 9'd7, 0, 0, dk, bn, rs, s1, s2, dp);
    chk("after_abort_latency", 32'(dk), 32'd11);
    chk("after_abort_result", 32'(rs), 32'd7);

    for (int it = 0; it < 14; it++) begin
      r  = $urandom_range(0, 9);
      l  = (r == 0) ? 9'd0 : (r == 1) ? 9'd1 : (r == 2) ? 9'd256 : 9'($urandom_range(2, 120));
      sd = (r == 3) ? 8'h00 : 8'($urandom);
      bb = 8'($urandom);
      md = $urandom_range(0, 2);
      pk = (l != 9'd0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, done_at(l) - 1) : 0;
      run_txn(sd, bb, l, md, pk, dk, bn, rs, s1, s2, dp);
      chk("rnd_latency", 32'(dk), 32'(done_at(l)));
      if (md == 0) chk("rnd_ones", 32'(rs), 32'(l));
      if (l != 9'd0) chk("rnd_load_s", 32'(s1), 32'((sd == 8'h00) ? 8'h01 : sd));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
